// File: rtl/m68k_rom_bridge_if.sv
// Bus bundle between the 68040-side decode, the ROM bridge and the ROM controller.
// cpu_ts_n is low for one clock and opens a cycle. Each beat ends with exactly one
// TA_n or TEA_n pulse. rom_stb is a one-clock request, and rom_ack is a one-clock
// reply that may arrive any number of clocks later. There is no back-pressure.
interface m68k_rom_bridge_if #(
  parameter int ROM_AW = 22
) ();
  logic              cpu_ts_n;
  logic              cpu_rw;
  logic [1:0]        cpu_siz;
  logic [31:0]       cpu_addr;
  logic              rom_cs;
  logic              cpu_ta_n;
  logic              cpu_tea_n;
  logic [31:0]       cpu_data_o;
  logic              cpu_data_oe;
  logic              rom_stb;
  logic [3:0]        rom_sel;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack;
  logic [31:0]       rom_idata;

  modport master (
    input  cpu_ts_n, cpu_rw, cpu_siz, cpu_addr, rom_cs, rom_ack, rom_idata,
    output cpu_ta_n, cpu_tea_n, cpu_data_o, cpu_data_oe, rom_stb, rom_sel, rom_addr
  );

  modport slave (
    output cpu_ts_n, cpu_rw, cpu_siz, cpu_addr, rom_cs, rom_ack, rom_idata,
    input  cpu_ta_n, cpu_tea_n, cpu_data_o, cpu_data_oe, rom_stb, rom_sel, rom_addr
  );
endinterface

// File: rtl/m68k_rom_bridge.sv
// 68040 read front end for the boot ROM. It splits CPU cycles into longword ROM
// requests, rejects writes, and turns a hung ROM into a bus error.
module m68k_rom_bridge #(
  parameter int ROM_AW  = 22,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  m68k_rom_bridge_if.master   bus,
  output logic [2:0]          dbg_state_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              stale_q, stale_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        siz_q, siz_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       data_q, data_d;
  logic              oe_q, oe_d;
  logic              stb_q, stb_d;
  logic              ta_n_q, ta_n_d;
  logic              tea_n_q, tea_n_d;

  function automatic logic [3:0] lane_sel(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] s;
    case (siz)
      SIZ_WORD: s = a[1] ? 4'b0011 : 4'b1100;
      SIZ_BYTE: s = 4'b1000 >> a;
      SIZ_LONG,
      SIZ_LINE: s = 4'b1111;
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
      siz_q   <= 2'b00;
      addr_q  <= '0;
      sel_q   <= 4'b0000;
      data_q  <= 32'h0;
      oe_q    <= 1'b0;
      stb_q   <= 1'b0;
      ta_n_q  <= 1'b1;
      tea_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
      siz_q   <= siz_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      stb_q   <= stb_d;
      ta_n_q  <= ta_n_d;
      tea_n_q <= tea_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    // An ack owed to a timed-out request is swallowed wherever it lands.
    stale_d = stale_q & ~bus.rom_ack;
    cnt_d   = cnt_q;
    siz_d   = siz_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    oe_d    = oe_q;
    stb_d   = 1'b0;
    ta_n_d  = 1'b1;
    tea_n_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (!bus.cpu_ts_n && bus.rom_cs) begin
          addr_d = bus.cpu_addr[ROM_AW+1:2];
          siz_d  = bus.cpu_siz;
          sel_d  = lane_sel(bus.cpu_siz, bus.cpu_addr[1:0]);
          beat_d = 2'd0;
          if (!bus.cpu_rw) begin
            tea_n_d = 1'b0;
            state_d = ERR;
          end else begin
            oe_d    = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (!stale_q) begin
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.rom_ack) begin
          data_d  = bus.rom_idata;
          ta_n_d  = 1'b0;
          state_d = ACK;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          stale_d = 1'b1;
          oe_d    = 1'b0;
          tea_n_d = 1'b0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK: begin
        if (siz_q == SIZ_LINE && beat_q != 2'd3) begin
          beat_d      = beat_q + 2'd1;
          addr_d[1:0] = addr_q[1:0] + 2'd1;
          state_d     = REQ;
        end else begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  if (ROM_AW < 30) begin : g_unused
    logic unused_addr;
    assign unused_addr = ^bus.cpu_addr[31:ROM_AW+2];
  end

  assign bus.cpu_ta_n    = ta_n_q;
  assign bus.cpu_tea_n   = tea_n_q;
  assign bus.cpu_data_o  = data_q;
  assign bus.cpu_data_oe = oe_q;
  assign bus.rom_stb     = stb_q;
  assign bus.rom_sel     = sel_q;
  assign bus.rom_addr    = addr_q;
  assign dbg_state_o     = state_q;
endmodule
